// File: rtl/int_controller_pkg.sv
// Shared encodings for the interrupt controller: FSM states, register map,
// STATUS bit positions and the CP0-style enable/disable levels.
package int_controller_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    localparam logic [1:0] ADDR_ENABLE  = 2'd0;
    localparam logic [1:0] ADDR_PENDING = 2'd1;
    localparam logic [1:0] ADDR_STATUS  = 2'd2;

    localparam int STAT_SPURIOUS   = 8;
    localparam int STAT_IN_SERVICE = 7;
    localparam int STAT_INT        = 6;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    function automatic logic [31:0] status_word(input logic       spurious,
                                                input logic       in_svc,
                                                input logic       int_req,
                                                input logic [3:0] id);
        logic [31:0] w;
        w                  = 32'd0;
        w[STAT_SPURIOUS]   = spurious;
        w[STAT_IN_SERVICE] = in_svc;
        w[STAT_INT]        = int_req;
        w[3:0]             = id;
        return w;
    endfunction

endpackage

// File: rtl/int_controller_prio_enc.sv
// Lowest-index-wins priority encoder: index 0 is the highest priority.
module int_controller_prio_enc #(
    parameter int N_SRC = 8,
    parameter int ID_W  = 4
) (
    input  logic [N_SRC-1:0] req,
    output logic             valid,
    output logic [ID_W-1:0]  idx
);

    always_comb begin
        valid = |req;
        idx   = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) idx = ID_W'(i);
        end
    end

endmodule

// File: rtl/int_controller.sv
// Interrupt aggregator: edge-latched pending bits gated by ENABLE, one fixed-
// priority request to CP0 held until INT_ACK, then blocked until EOI.
//
// state     | meaning
// S_IDLE    | no request outstanding, arbitrating enabled pending sources
// S_REQ     | INT high, int_id frozen, waiting for INT_ACK
// S_SERVICE | acknowledged, handler running, waiting for eoi
module int_controller
    import int_controller_pkg::*;
#(
    parameter int N_SRC = 8,
    parameter int ID_W  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_in,
    output logic             INT,
    input  logic             INT_ACK,
    input  logic             eoi,
    input  logic             reg_we,
    input  logic             reg_re,
    input  logic [1:0]       reg_addr,
    input  logic [31:0]      reg_wdata,
    output logic [31:0]      reg_rdata,
    output logic [ID_W-1:0]  int_id,
    output logic             in_service
);

    state_t            state, state_nxt;
    logic [N_SRC-1:0]  irq_prev, enable_r, pending, pending_nxt;
    logic [N_SRC-1:0]  rise, cand;
    logic [ID_W-1:0]   win_idx, id_nxt;
    logic              win_valid, ack_take, spur_set, spurious;
    logic [31:0]       read_val;
    logic              unused_wdata;

    assign unused_wdata = ^reg_wdata;

    assign rise       = irq_in & ~irq_prev;
    assign cand       = pending & enable_r;
    assign INT        = (state == S_REQ);
    assign in_service = (state == S_SERVICE);

    int_controller_prio_enc #(.N_SRC(N_SRC), .ID_W(ID_W)) u_prio_enc (
        .req   (cand),
        .valid (win_valid),
        .idx   (win_idx)
    );

    always_comb begin
        state_nxt = state;
        id_nxt    = int_id;
        ack_take  = 1'b0;
        case (state)
            S_IDLE: begin
                if (win_valid) begin
                    state_nxt = S_REQ;
                    id_nxt    = win_idx;
                end
            end
            S_REQ: begin
                if (INT_ACK) begin
                    ack_take  = 1'b1;
                    state_nxt = S_SERVICE;
                end
            end
            S_SERVICE: begin
                if (eoi) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        spur_set = INT_ACK && (state != S_REQ);
    end

    // Rising edges are OR-ed in last so they beat both W1C and the ack clear.
    always_comb begin
        pending_nxt = pending;
        if (reg_we && reg_addr == ADDR_PENDING) pending_nxt = pending_nxt & ~reg_wdata[N_SRC-1:0];
        if (ack_take) pending_nxt = pending_nxt & ~(N_SRC'(1) << int_id);
        pending_nxt = pending_nxt | rise;
    end

    always_comb begin
        read_val = 32'd0;
        case (reg_addr)
            ADDR_ENABLE:  read_val = 32'(enable_r);
            ADDR_PENDING: read_val = 32'(pending);
            ADDR_STATUS:  read_val = status_word(spurious, in_service, INT, 4'(int_id));
            default:      read_val = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            int_id    <= '0;
            irq_prev  <= '0;
            enable_r  <= '0;
            pending   <= '0;
            spurious  <= DISABLE;
            reg_rdata <= 32'd0;
        end else begin
            state     <= state_nxt;
            int_id    <= id_nxt;
            irq_prev  <= irq_in;
            pending   <= pending_nxt;
            reg_rdata <= reg_re ? read_val : 32'd0;
            if (reg_we && reg_addr == ADDR_ENABLE) enable_r <= reg_wdata[N_SRC-1:0];
            if (spur_set) spurious <= ENABLE;
            else if (reg_we && reg_addr == ADDR_STATUS && reg_wdata[STAT_SPURIOUS]) spurious <= DISABLE;
        end
    end

endmodule

// File: doc/int_controller.md
Name: int_controller

Overview:
- Interrupt source aggregator that drives the CPU-side INT line into the coprocessor-0 block and consumes its INT_ACK.
- Latches edge events from N_SRC peripheral lines into a pending register and gates them with a software enable register.
- Picks one winner by fixed priority, holds INT until acknowledged, then blocks further requests until software signals end-of-interrupt (EOI).
- Software reaches enable, pending and status through a small register port mapped behind mtc0/mfc0-style accesses or MMIO.

Parameters:
N_SRC, 8, number of interrupt sources (1..16)
ID_W, 4, width of source ID field; must satisfy 2^ID_W >= N_SRC

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-low reset
irq_in  in  N_SRC  peripheral request lines, already synchronous to clk, rising-edge sensitive
INT  out  1  interrupt request to coprocessor 0
INT_ACK  in  1  one-cycle acknowledge pulse from coprocessor 0
eoi  in  1  one-cycle end-of-interrupt strobe from software/decoder
reg_we  in  1  register write strobe
reg_re  in  1  register read strobe
reg_addr  in  2  0=ENABLE, 1=PENDING, 2=STATUS, 3=reserved
reg_wdata  in  32  write data
reg_rdata  out  32  read data, registered
int_id  out  ID_W  ID of the source currently requested or in service
in_service  out  1  high from acknowledge until EOI

Behaviour:
- Reset (reset==0 at posedge): INT=0, int_id=0, in_service=0, reg_rdata=0, ENABLE=0 (all sources disabled), PENDING=0, irq_prev=0, spurious=0, state=IDLE.
- Edge detect: rise[i] = irq_in[i] & ~irq_prev[i]; irq_prev <= irq_in every cycle. A rise sets PENDING[i] regardless of ENABLE. A held-high line sets PENDING only once.
- Candidates = PENDING & ENABLE. Winner = lowest set index (index 0 is highest priority).
- FSM states: IDLE, REQ, SERVICE.
- IDLE:
  - If candidates != 0: latch int_id = winner, INT<=1, go to REQ. INT rises 1 cycle after the PENDING bit becomes visible.
  - If candidates == 0: remain in IDLE.
- REQ:
  - INT is held at 1 and int_id is frozen. No preemption: a higher-priority arrival waits.
  - Disabling or clearing the winner in REQ does not withdraw INT.
  - On INT_ACK: clear PENDING[int_id], INT<=0, in_service<=1, go to SERVICE.
  - A rise on the same source in the acknowledge cycle wins, so that PENDING bit stays 1.
- SERVICE:
  - INT stays 0 and no new request is issued.
  - On eoi: in_service<=0, go to IDLE. Next arbitration happens in the cycle after EOI, so INT can re-rise 2 cycles after the eoi pulse.
- Ignored strobes: INT_ACK outside REQ is ignored and sets STATUS.spurious (sticky). eoi outside SERVICE is ignored.
- Register writes, applied at posedge:
  - ENABLE <= reg_wdata[N_SRC-1:0].
  - PENDING is write-1-to-clear; a same-cycle rise overrides the clear.
  - STATUS write of bit 8 = 1 clears spurious; writes to other STATUS bits are ignored. Reserved-address writes are ignored.
- Register reads: reg_rdata is updated on the posedge after reg_re (1-cycle latency) and is 0 when reg_re=0.
  - ENABLE and PENDING read zero-extended.
  - STATUS = {23'b0, spurious, in_service, INT, 2'b0, int_id zero-extended to 4 bits}.
  - Reserved address reads 0.
- Same-cycle ordering: the arbitration decision uses pre-write ENABLE and PENDING; the effect of a register write appears in the next cycle.
- Reset asserted mid-REQ or mid-SERVICE: everything returns to reset values next posedge and INT drops immediately.

Decomposition:
- Shared package/define file holds: the state encodings (IDLE/REQ/SERVICE), register addresses (ENABLE/PENDING/STATUS), the STATUS bit positions, and ENABLE/DISABLE macros matching the existing CP0 defines.
- Sub-module prio_enc (N_SRC-wide lowest-index priority encoder: valid + index), instantiated once.

Test Plan:
- Reset, ENABLE=0x04, pulse irq_in[2] -> INT=1 with int_id=2 two cycles after the edge. Pulse INT_ACK -> INT=0, in_service=1, PENDING=0. Pulse eoi -> in_service=0.
- ENABLE=0xFF, raise irq_in[5] and irq_in[1] in the same cycle -> int_id=1. After ack and eoi -> INT re-asserts with int_id=5 within 2 cycles.
- In REQ for source 3, raise irq_in[0] -> int_id stays 3 until ack. After eoi, source 0 is served.
- ENABLE=0, edge on irq_in[4] -> PENDING=0x10 and INT stays 0. Write ENABLE=0x10 -> INT=1 next cycle. Write PENDING=0x10 while in IDLE with ENABLE=0 -> PENDING reads 0.
- INT_ACK pulse while in IDLE -> STATUS bit 8 = 1 and no state change. Write STATUS=0x100 -> bit 8 clears.
- Assert reset (reset=0) while in SERVICE -> next cycle INT=0, in_service=0, ENABLE=0, STATUS reads 0.
